pipeline_stall_control: RTL and testbench

Central pipeline-control block for the 5-stage LC-3b pipeline. It consumes the hazard requests from the forwarding unit (`stall_forwarding`, `flush_forwarding`), the memory handshakes and branch resolution. It drives the per-stage register load and flush controls, the PC load and redirect select, a saturating stall-cycle counter and a sticky memory-timeout flag. It is the receiving end of the forwarding unit's stall/flush interface, and the only block that writes pipeline-register enables.

---
 rtl/pipeline_stall_control.sv | 178 +++++++++++++++++
 tb/tb_pipeline_stall_control.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_control.sv
// LC-3b pipeline control: turns hazard, memory-handshake and branch requests into stage load/flush and PC controls.
// Latency: controls are combinational from state and inputs. Backpressure: a pending d-mem access freezes every stage.
module pipeline_stall_control #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_forwarding,
    input  logic             flush_forwarding,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             br_taken,
    output logic             load_pc,
    output logic             pc_sel_saved,
    output logic             save_br_target,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LOAD_USE = 2'd1,
        S_BR_PEND  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_wait_cnt;
    logic [15:0]      w_wait_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_timeout;
    logic             w_dmem_wait;
    logic             w_imem_wait;
    logic             w_hazard;
    logic             w_wait_cycle;

    assign w_dmem_wait = dmem_req & ~dmem_resp;
    assign w_imem_wait = imem_req & ~imem_resp;
    assign w_hazard    = stall_forwarding & flush_forwarding;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_dmem_wait) begin
            case (r_state)
                S_RUN: begin
                    if (br_taken) begin
                        if (w_imem_wait) begin
                            w_state_nxt = S_BR_PEND;
                        end
                    end else if (w_hazard) begin
                        w_state_nxt = S_LOAD_USE;
                    end
                end
                S_LOAD_USE: w_state_nxt = S_RUN;
                S_BR_PEND: begin
                    if (imem_resp) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    always_comb begin
        load_pc        = 1'b1;
        pc_sel_saved   = 1'b0;
        save_br_target = 1'b0;
        load_if_id     = 1'b1;
        load_id_ex     = 1'b1;
        load_ex_mem    = 1'b1;
        load_mem_wb    = 1'b1;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        flush_ex_mem   = 1'b0;
        w_wait_cycle   = 1'b0;
        if (reset) begin
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            load_id_ex   = 1'b0;
            load_ex_mem  = 1'b0;
            load_mem_wb  = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (w_dmem_wait) begin
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            load_id_ex   = 1'b0;
            load_ex_mem  = 1'b0;
            load_mem_wb  = 1'b0;
            w_wait_cycle = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (br_taken) begin
                        flush_if_id    = 1'b1;
                        flush_id_ex    = 1'b1;
                        flush_ex_mem   = 1'b1;
                        save_br_target = 1'b1;
                        load_pc        = ~w_imem_wait;
                    end else if (w_hazard) begin
                        load_pc      = 1'b0;
                        load_if_id   = 1'b0;
                        load_id_ex   = 1'b0;
                        flush_ex_mem = 1'b1;
                    end else if (w_imem_wait) begin
                        load_pc      = 1'b0;
                        flush_if_id  = 1'b1;
                        w_wait_cycle = 1'b1;
                    end
                end
                // The load has already advanced, so a repeated hazard request is stale here.
                S_LOAD_USE: begin
                    if (w_imem_wait) begin
                        load_pc      = 1'b0;
                        flush_if_id  = 1'b1;
                        w_wait_cycle = 1'b1;
                    end
                end
                S_BR_PEND: begin
                    flush_if_id = 1'b1;
                    if (imem_resp) begin
                        pc_sel_saved = 1'b1;
                    end else begin
                        load_pc      = 1'b0;
                        w_wait_cycle = 1'b1;
                    end
                end
                default: begin
                    load_pc = 1'b1;
                end
            endcase
        end
    end

    assign w_wait_nxt = !w_wait_cycle          ? 16'd0      :
                        (r_wait_cnt == 16'hFFFF) ? r_wait_cnt :
                        r_wait_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_wait_cnt  <= 16'd0;
            r_timeout   <= 1'b0;
        end else begin
            if (!load_pc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_cycle && (w_wait_nxt >= 16'(TIMEOUT))) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign stall_count = r_stall_cnt;
    assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_pipeline_stall_control.sv
// Bench for pipeline_stall_control: directed vector table, hand-written timeout/saturation sequences,
// then random traffic against a flag-and-counter reference model.
module tb_pipeline_stall_control;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, stall_forwarding, flush_forwarding;
    logic             imem_req, imem_resp, dmem_req, dmem_resp, br_taken;
    logic             load_pc, pc_sel_saved, save_br_target;
    logic             load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic             flush_if_id, flush_id_ex, flush_ex_mem;
    logic [CNT_W-1:0] stall_count;
    logic             mem_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_control #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_forwarding (stall_forwarding),
        .flush_forwarding (flush_forwarding),
        .imem_req         (imem_req),
        .imem_resp        (imem_resp),
        .dmem_req         (dmem_req),
        .dmem_resp        (dmem_resp),
        .br_taken         (br_taken),
        .load_pc          (load_pc),
        .pc_sel_saved     (pc_sel_saved),
        .save_br_target   (save_br_target),
        .load_if_id       (load_if_id),
        .load_id_ex       (load_id_ex),
        .load_ex_mem      (load_ex_mem),
        .load_mem_wb      (load_mem_wb),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .flush_ex_mem     (flush_ex_mem),
        .stall_count      (stall_count),
        .mem_timeout      (mem_timeout)
    );

    // inputs: {reset, stall_fwd, flush_fwd, imem_req, imem_resp, dmem_req, dmem_resp, br_taken}
    // outputs: {load_pc, pc_sel_saved, save_br_target, load_if_id..load_mem_wb, flush_if_id..flush_ex_mem}
    typedef struct {
        logic [7:0] in;
        logic [9:0] out;
        int         cnt;
        logic       to;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [9:0] dut_out();
        return {load_pc, pc_sel_saved, save_br_target,
                load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                flush_if_id, flush_id_ex, flush_ex_mem};
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [7:0] v);
        {reset, stall_forwarding, flush_forwarding, imem_req, imem_resp,
         dmem_req, dmem_resp, br_taken} = v;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{8'b1_11_10_00_1, 10'b000_0000_111, 0,  1'b0};
        tbl[1]  = '{8'b1_00_00_10_0, 10'b000_0000_111, 0,  1'b0};
        tbl[2]  = '{8'b0_11_00_00_0, 10'b000_0011_001, 0,  1'b0};
        tbl[3]  = '{8'b0_11_00_00_0, 10'b100_1111_000, 1,  1'b0};
        tbl[4]  = '{8'b0_00_00_00_0, 10'b100_1111_000, 1,  1'b0};
        tbl[5]  = '{8'b0_00_00_00_1, 10'b101_1111_111, 1,  1'b0};
        tbl[6]  = '{8'b0_00_10_00_1, 10'b001_1111_111, 1,  1'b0};
        tbl[7]  = '{8'b0_00_10_00_0, 10'b000_1111_100, 2,  1'b0};
        tbl[8]  = '{8'b0_00_10_00_0, 10'b000_1111_100, 3,  1'b0};
        tbl[9]  = '{8'b0_00_11_00_0, 10'b110_1111_100, 4,  1'b0};
        tbl[10] = '{8'b0_00_00_00_0, 10'b100_1111_000, 4,  1'b0};
        tbl[11] = '{8'b0_11_00_10_1, 10'b000_0000_000, 4,  1'b0};
        tbl[12] = '{8'b0_11_00_11_1, 10'b101_1111_111, 5,  1'b0};
        tbl[13] = '{8'b0_00_10_00_0, 10'b000_1111_100, 5,  1'b0};
        tbl[14] = '{8'b0_00_00_00_0, 10'b100_1111_000, 6,  1'b0};
        tbl[15] = '{8'b0_00_10_00_1, 10'b001_1111_111, 6,  1'b0};
        tbl[16] = '{8'b0_00_11_10_0, 10'b000_0000_000, 7,  1'b0};
        tbl[17] = '{8'b0_00_11_11_0, 10'b110_1111_100, 8,  1'b0};
        tbl[18] = '{8'b0_11_00_00_0, 10'b000_0011_001, 8,  1'b0};
        tbl[19] = '{8'b0_11_10_00_0, 10'b000_1111_100, 9,  1'b0};
        tbl[20] = '{8'b0_00_00_00_0, 10'b100_1111_000, 10, 1'b0};

        {reset, stall_forwarding, flush_forwarding, imem_req, imem_resp,
         dmem_req, dmem_resp, br_taken} = 8'b1000_0000;
        tick();

        for (int i = 0; i < 21; i++) begin
            apply(tbl[i].in);
            check($sformatf("tbl%0d_ctrl", i), int'(dut_out()), int'(tbl[i].out));
            check($sformatf("tbl%0d_cnt", i), int'(stall_count), tbl[i].cnt);
            check($sformatf("tbl%0d_to", i), int'(mem_timeout), int'(tbl[i].to));
            tick();
        end

        // d-mem wait with no response: flag visible after the TIMEOUT-th wait cycle, then sticky
        for (int k = 1; k <= 6; k++) begin
            apply(8'b0_00_00_10_0);
            check($sformatf("timeout_wait%0d", k), int'(mem_timeout), (k > TIMEOUT) ? 1 : 0);
            tick();
        end
        apply(8'b0_00_00_11_0);
        check("timeout_after_resp", int'(mem_timeout), 1);
        tick();
        apply(8'b0_00_00_00_0);
        check("timeout_idle", int'(mem_timeout), 1);
        tick();
        apply(8'b1_00_00_00_0);
        check("timeout_in_reset", int'(mem_timeout), 1);
        check("reset_ctrl", int'(dut_out()), int'(10'b000_0000_111));
        tick();
        apply(8'b0_00_00_00_0);
        check("timeout_cleared", int'(mem_timeout), 0);
        check("cnt_cleared", int'(stall_count), 0);
        tick();

        // 20 cycles of fetch wait: stall count climbs then holds at all-ones
        for (int k = 1; k <= 20; k++) begin
            apply(8'b0_00_10_00_0);
            check($sformatf("sat_cnt%0d", k), int'(stall_count), (k - 1 > SAT) ? SAT : k - 1);
            tick();
        end
        apply(8'b0_00_00_00_0);
        check("sat_hold", int'(stall_count), SAT);
        tick();

        // Random traffic versus reference model
        begin
            bit m_pend, m_lu, m_to;
            int m_waits, m_stalls;
            apply(8'b1000_0000);
            tick();
            m_pend = 0; m_lu = 0; m_to = 0; m_waits = 0; m_stalls = 0;
            for (int n = 0; n < 3000; n++) begin
                logic rst, sf, ff, ireq, iresp, dreq, dresp, br;
                logic lp, ps, sv, lif, lid, lex, lmw, fif, fid, fex;
                bit waiting, imem_wait;
                rst   = ($urandom_range(0, 79) == 0);
                sf    = ($urandom_range(0, 2) == 0);
                ff    = sf ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
                ireq  = 1'($urandom_range(0, 1));
                iresp = ($urandom_range(0, 2) == 0);
                dreq  = ($urandom_range(0, 3) == 0);
                dresp = 1'($urandom_range(0, 1));
                br    = ($urandom_range(0, 7) == 0);
                imem_wait = ireq && !iresp;

                lp = 1; ps = 0; sv = 0; lif = 1; lid = 1; lex = 1; lmw = 1;
                fif = 0; fid = 0; fex = 0; waiting = 0;
                if (rst) begin
                    lp = 0; lif = 0; lid = 0; lex = 0; lmw = 0;
                    fif = 1; fid = 1; fex = 1;
                end else if (dreq && !dresp) begin
                    lp = 0; lif = 0; lid = 0; lex = 0; lmw = 0;
                    waiting = 1;
                end else if (m_pend) begin
                    fif = 1;
                    if (iresp) begin ps = 1; m_pend = 0; end
                    else begin lp = 0; waiting = 1; end
                end else if (m_lu) begin
                    m_lu = 0;
                    if (imem_wait) begin lp = 0; fif = 1; waiting = 1; end
                end else if (br) begin
                    fif = 1; fid = 1; fex = 1; sv = 1;
                    if (imem_wait) begin lp = 0; m_pend = 1; end
                end else if (sf && ff) begin
                    lp = 0; lif = 0; lid = 0; fex = 1; m_lu = 1;
                end else if (imem_wait) begin
                    lp = 0; fif = 1; waiting = 1;
                end

                apply({rst, sf, ff, ireq, iresp, dreq, dresp, br});
                check($sformatf("rnd%0d_ctrl", n), int'(dut_out()),
                      int'({lp, ps, sv, lif, lid, lex, lmw, fif, fid, fex}));
                check($sformatf("rnd%0d_cnt", n), int'(stall_count), m_stalls);
                check($sformatf("rnd%0d_to", n), int'(mem_timeout), int'(m_to));
                tick();

                if (rst) begin
                    m_pend = 0; m_lu = 0; m_to = 0; m_waits = 0; m_stalls = 0;
                end else begin
                    if (!lp && m_stalls < SAT) m_stalls++;
                    m_waits = waiting ? m_waits + 1 : 0;
                    if (m_waits >= TIMEOUT) m_to = 1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
